imem_loader: RTL

- Write-side companion to the byte-wide instruction memory.
- Accepts 16-bit instruction words over a valid/ready stream and writes each word as two big-endian bytes: high byte at the even address A, low byte at A+1. This matches the fetch order {mem[PC], mem[PC+1]}.
- Asserts cpu_hold for the whole load so the core does not fetch while the program is being written.

---
 rtl/imem_loader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Streams 16-bit instruction words into the byte-wide instruction memory,
// high byte at the even address, and holds the core off while loading.
module imem_loader #(
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned CNT_W  = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   input  logic              abort,
   input  logic              in_valid,
   input  logic [15:0]       in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              busy,
   output logic              cpu_hold,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ACCEPT = 3'd1,
      WR_HI  = 3'd2,
      WR_LO  = 3'd3,
      DONE   = 3'd4
   } state_e;

   state_e            state_q,     state_d;
   logic [ADDR_W-1:0] cur_addr_q,  cur_addr_d;
   logic [CNT_W-1:0]  remaining_q, remaining_d;
   logic [7:0]        lo_byte_q,   lo_byte_d;
   logic              abort_q,     abort_d;
   logic              mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;
   logic              err_q,       err_d;
   logic              abort_eff;

   assign abort_eff = abort | abort_q;

   // Next-state logic; write strobes are set up one cycle ahead so they leave registers.
   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      lo_byte_d   = lo_byte_q;
      abort_d     = abort_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      err_d       = 1'b0;

      case (state_q)
         IDLE: begin
            abort_d = 1'b0;
            if (start) begin
               if ((word_count != CNT_W'(0)) && !base_addr[0]) begin
                  cur_addr_d  = base_addr;
                  remaining_d = word_count;
                  state_d     = ACCEPT;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ACCEPT: begin
            // A pending abort takes precedence over a word offered in the same cycle.
            if (abort_eff) begin
               abort_d = 1'b0;
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (in_valid) begin
               lo_byte_d   = in_data[7:0];
               mem_we_d    = 1'b1;
               mem_addr_d  = cur_addr_q;
               mem_wdata_d = in_data[15:8];
               state_d     = WR_HI;
            end
         end
         WR_HI: begin
            if (abort) abort_d = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = {cur_addr_q[ADDR_W-1:1], 1'b1};
            mem_wdata_d = lo_byte_q;
            state_d     = WR_LO;
         end
         WR_LO: begin
            cur_addr_d  = ADDR_W'(cur_addr_q + ADDR_W'(2));
            remaining_d = CNT_W'(remaining_q - CNT_W'(1));
            if (abort_eff) begin
               abort_d = 1'b0;
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (remaining_q == CNT_W'(1)) begin
               state_d = DONE;
            end else begin
               state_d = ACCEPT;
            end
         end
         DONE: begin
            abort_d = 1'b0;
            state_d = IDLE;
         end
         default: begin
            abort_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         lo_byte_q   <= '0;
         abort_q     <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
         lo_byte_q   <= lo_byte_d;
         abort_q     <= abort_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         err_q       <= err_d;
      end
   end

   assign in_ready  = (state_q == ACCEPT);
   assign busy      = (state_q != IDLE);
   assign cpu_hold  = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign err       = err_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule
